// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 2-digit
// multiplexed common-anode 7-segment display from a 6-bit count.
module count_display_driver #(
    parameter int REFRESH_CYCLES = 27000,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] count_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state_q, state_d;
    logic [13:0]      shreg_q, shreg_d;   // {tens[3:0], units[3:0], bin[5:0]}
    logic [2:0]       iter_q, iter_d;
    logic [5:0]       last_q, last_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic             busy_q, done_q;
    logic [CNT_W-1:0] refresh_q;
    logic             sel_q;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;

    function automatic logic [13:0] dabble_adjust(input logic [13:0] r);
        logic [13:0] a;
        a = r;
        if (a[9:6] >= 4'd5)
            a[9:6] = a[9:6] + 4'd3;
        if (a[13:10] >= 4'd5)
            a[13:10] = a[13:10] + 4'd3;
        return a;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        last_d  = last_q;
        units_d = units_q;
        tens_d  = tens_q;
        case (state_q)
            IDLE: begin
                if (count_i != last_q) begin
                    shreg_d = {8'd0, count_i};
                    last_d  = count_i;
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = dabble_adjust(shreg_q) << 1;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd5)
                    state_d = LOAD;
            end
            LOAD: begin
                units_d = shreg_q[9:6];
                tens_d  = shreg_q[13:10];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            iter_q  <= 3'd0;
            last_q  <= 6'd0;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            last_q  <= last_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == LOAD);
        end
    end

    // Scratch register carries data only; it is always reloaded before use.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q <= '0;
            sel_q     <= 1'b0;
        end else if (refresh_q == CNT_MAX) begin
            refresh_q <= '0;
            sel_q     <= ~sel_q;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= 7'h7F;
            an_q  <= 2'b11;
        end else if (!sel_q) begin
            seg_q <= seg_pattern(units_q);
            an_q  <= 2'b10;
        end else begin
            seg_q <= (BLANK_LZ && tens_q == 4'd0) ? 7'h7F : seg_pattern(tens_q);
            an_q  <= 2'b01;
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: two instances (leading-zero blanking on/off)
// share clock, reset and count; digits and scan timing are checked per vector.
module tb_count_display_driver;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] count;
    logic [6:0] seg, seg0;
    logic [1:0] an, an0;
    logic       busy, busy0, done, done0;

    count_display_driver #(.REFRESH_CYCLES(R), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .count_i(count),
        .seg_o(seg), .an_o(an), .busy_o(busy), .done_o(done)
    );
    count_display_driver #(.REFRESH_CYCLES(R), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .count_i(count),
        .seg_o(seg0), .an_o(an0), .busy_o(busy0), .done_o(done0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] cnt;
        logic [6:0] u;
        logic [6:0] t;
        logic [6:0] t0;
    } vec_t;

    vec_t       vecs[10];
    vec_t       sbq[$];
    logic [6:0] pat[10];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit drive, input string tag);
        int lat;
        logic [6:0] su, st, su0, st0;
        bit gu, gt;
        vec_t e;
        if (drive) count = v.cnt;
        sbq.push_back(v);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 32'd8);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        e = sbq.pop_front();
        gu = 1'b0; gt = 1'b0;
        su = 'x; st = 'x; su0 = 'x; st0 = 'x;
        for (int k = 0; k < 2*R+2; k++) begin
            @(negedge clk);
            if (an == 2'b10 && !gu) begin gu = 1'b1; su = seg; su0 = seg0; end
            if (an == 2'b01 && !gt) begin gt = 1'b1; st = seg; st0 = seg0; end
        end
        chk({tag, "_units_phase_seen"}, 32'(gu), 32'd1);
        chk({tag, "_tens_phase_seen"}, 32'(gt), 32'd1);
        chk({tag, "_units_seg"}, 32'(su), 32'(e.u));
        chk({tag, "_tens_seg"}, 32'(st), 32'(e.t));
        chk({tag, "_units_seg_nolz"}, 32'(su0), 32'(e.u));
        chk({tag, "_tens_seg_nolz"}, 32'(st0), 32'(e.t0));
    endtask

    task automatic check_scan(input int n, input string tag, input logic [6:0] eu, input logic [6:0] et);
        logic [1:0] prev;
        int run, trans, bad, bz, dn, ill, segerr, mism0;
        run = 1; trans = 0; bad = 0; bz = 0; dn = 0; ill = 0; segerr = 0; mism0 = 0;
        @(negedge clk);
        prev = an;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (an !== prev) begin
                if (trans > 0 && run != R) bad++;
                trans++;
                run = 1;
                prev = an;
            end else begin
                run++;
            end
            if (busy !== 1'b0) bz++;
            if (done !== 1'b0) dn++;
            if (an !== 2'b10 && an !== 2'b01) ill++;
            if (an == 2'b10 && seg !== eu) segerr++;
            if (an == 2'b01 && seg !== et) segerr++;
            if (busy0 !== busy || done0 !== done || an0 !== an) mism0++;
        end
        chk({tag, "_busy_activity"}, bz, 32'd0);
        chk({tag, "_done_activity"}, dn, 32'd0);
        chk({tag, "_run_len_errors"}, bad, 32'd0);
        chk({tag, "_illegal_an"}, ill, 32'd0);
        chk({tag, "_seg_errors"}, segerr, 32'd0);
        chk({tag, "_instance_mismatch"}, mism0, 32'd0);
        chk({tag, "_enough_toggles"}, 32'(trans >= n / R - 2), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tmp;
        int dcount, firstd, secondd, saw45;
        bit saw12;
        logic [6:0] lu, lt;

        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
        pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;

        vecs[0] = '{6'd5,  7'h12, 7'h7F, 7'h40};
        vecs[1] = '{6'd63, 7'h30, 7'h02, 7'h02};
        vecs[2] = '{6'd10, 7'h40, 7'h79, 7'h79};
        vecs[3] = '{6'd0,  7'h40, 7'h7F, 7'h40};
        vecs[4] = '{6'd9,  7'h10, 7'h7F, 7'h40};
        vecs[5] = '{6'd59, 7'h10, 7'h12, 7'h12};
        vecs[6] = '{6'd48, 7'h00, 7'h19, 7'h19};
        vecs[7] = '{6'd21, 7'h79, 7'h24, 7'h24};
        vecs[8] = '{6'd60, 7'h40, 7'h02, 7'h02};
        vecs[9] = '{6'd37, 7'h78, 7'h30, 7'h30};

        // Reset held with a nonzero count: display dark, converter idle.
        rst = 1'b0;
        count = 6'd37;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d_seg", i), 32'(seg), 32'h7F);
            chk($sformatf("reset%0d_an", i), 32'(an), 32'd3);
            chk($sformatf("reset%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("reset%0d_done", i), 32'(done), 32'd0);
        end
        rst = 1'b1;
        tmp = '{6'd37, 7'h78, 7'h30, 7'h30};
        run_vec(tmp, 1'b0, "first37");
        check_scan(20, "scan37", 7'h78, 7'h30);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

        for (int n = 0; n < 64; n++) begin
            tmp.cnt = 6'(n);
            tmp.u   = pat[n % 10];
            tmp.t   = (n / 10 == 0) ? 7'h7F : pat[n / 10];
            tmp.t0  = pat[n / 10];
            run_vec(tmp, 1'b1, $sformatf("sweep%0d", n));
        end

        // Count changes while converting: 12 completes, 45 skipped, 46 follows.
        count = 6'd12;
        dcount = 0; firstd = 0; secondd = 0; saw12 = 1'b0; saw45 = 0;
        lu = 'x; lt = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) count = 6'd45;
            if (k == 2) count = 6'd46;
            if (done) begin
                dcount++;
                if (dcount == 1) firstd = k;
                else if (dcount == 2) secondd = k;
            end
            if (an == 2'b10 && seg == 7'h24) saw12 = 1'b1;
            if (an == 2'b10 && seg == 7'h12) saw45++;
            if (k >= 18 && an == 2'b10) lu = seg;
            if (k >= 18 && an == 2'b01) lt = seg;
        end
        chk("skip_done_count", dcount, 32'd2);
        chk("skip_first_done", firstd, 32'd8);
        chk("skip_second_done", secondd, 32'd16);
        chk("skip_shown12", 32'(saw12), 32'd1);
        chk("skip_never45", saw45, 32'd0);
        chk("skip_final_units", 32'(lu), 32'h02);
        chk("skip_final_tens", 32'(lt), 32'h19);

        // Reset in the third SHIFT cycle of converting 59.
        count = 6'd59;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_pre%0d_done", k), 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk($sformatf("midrst%0d_busy", k), 32'(busy), 32'd0);
            chk($sformatf("midrst%0d_seg", k), 32'(seg), 32'h7F);
            chk($sformatf("midrst%0d_an", k), 32'(an), 32'd3);
            chk($sformatf("midrst%0d_done", k), 32'(done), 32'd0);
        end
        rst = 1'b1;
        tmp = '{6'd59, 7'h10, 7'h12, 7'h12};
        run_vec(tmp, 1'b0, "restart59");

        tmp = '{6'd30, 7'h40, 7'h30, 7'h30};
        run_vec(tmp, 1'b1, "hold30_load");
        check_scan(100, "hold30", 7'h40, 7'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Consumer of the 6-bit counter output (count_o, 0..63); drives a 2-digit multiplexed common-anode 7-segment display.
- Converts the binary count to two BCD digits with a sequential double-dabble FSM.
- Time-multiplexes the two digits with a refresh timer.
- Sits between the counter and the board display pins in the same clock domain.

Parameters:
- REFRESH_CYCLES, 27000, clock cycles each digit stays enabled before switching; legal range 2..2^20.
- BLANK_LZ, 1, when 1 the tens digit is blanked if it equals 0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- count_i  input  6  binary value from counter, 0..63.
- seg_o  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an_o  output  2  digit enables, active-low; an_o[0]=units, an_o[1]=tens.
- busy_o  output  1  high while a conversion is in progress.
- done_o  output  1  one-cycle pulse when new digits are loaded.

Behaviour:
- Reset (rst=0 at a rising edge):
  - FSM to IDLE; units_q, tens_q, last_q and refresh counter to 0; sel to 0.
  - seg_o=7'h7F (all off), an_o=2'b11, busy_o=0, done_o=0.
  - Reset mid-conversion abandons the conversion; digits stay 0.
- Converter FSM, states IDLE, SHIFT, LOAD:
  - IDLE: if count_i != last_q, capture count_i into the shift register, set last_q=count_i, clear the BCD scratch, go to SHIFT, busy_o=1. Otherwise stay.
  - The first edge after reset compares against last_q=0, so a count_i of 0 triggers no conversion.
  - SHIFT: exactly 6 cycles. Each cycle, any BCD nibble >= 5 gets +3, then the {bcd,bin} register shifts left by 1. A 3-bit iteration counter tracks the cycles.
  - LOAD: 1 cycle. units_q/tens_q are updated from the scratch, done_o=1 for this cycle, busy_o stays 1. Next state is IDLE, where busy_o=0.
  - Latency: edge sampling count_i in IDLE = E; done_o and the new digits take effect at edge E+7.
  - count_i changes during SHIFT/LOAD are ignored. On return to IDLE the current count_i is compared with last_q and reconverted if different. Intermediate values may be skipped; the final stable value is always displayed.
  - Range: tens 0..6, units 0..9. No overflow is possible with 6-bit input.
- Refresh/scan:
  - The refresh counter runs 0..REFRESH_CYCLES-1 continuously, independent of the FSM.
  - On wrap it returns to 0 and sel toggles.
- Output registers (updated every cycle after reset):
  - sel=0: an_o=2'b10, seg_o=pattern(units_q).
  - sel=1: an_o=2'b01, seg_o=pattern(tens_q). If BLANK_LZ=1 and tens_q=0, seg_o=7'h7F with an_o still 2'b01.
  - Patterns (active-low gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Values 10..15 are unreachable; map them to 7'h7F.
  - Digit update in LOAD is reflected on seg_o at the following edge.
- Outputs never glitch between legal patterns: all outputs are registered.

Test Plan (REFRESH_CYCLES=4):
- Reset held 3 cycles with count_i=37 -> seg_o=7F, an_o=11, busy_o=0 throughout. After release, busy_o rises next edge; done_o pulses exactly 7 edges after sampling; then alternates an_o=10/seg_o=78 ("7") and an_o=01/seg_o=30 ("3"), each held 4 cycles.
- count_i stepped 0..63 with each value held 20 cycles -> after each done_o, units_q=count%10 and tens_q=count/10. At 63: "6"=02 and "3"=30.
- count_i=5 with BLANK_LZ=1 -> tens phase seg_o=7F, an_o=01; units phase seg_o=12. Same run with BLANK_LZ=0 -> tens phase seg_o=40.
- count_i changes 12->45->46 on consecutive cycles during SHIFT -> the first conversion completes and shows "12". The next IDLE captures 46, with done_o 7 edges later. 45 is never displayed, and exactly two done_o pulses occur.
- rst asserted during the 3rd SHIFT cycle of converting 59 -> busy_o=0, seg_o=7F, an_o=11 next edge. No done_o. After release with count_i=59, conversion restarts and shows 5/9 (12/10).
- count_i held constant 30 for 100 cycles after the display is valid -> no further busy_o/done_o activity. an_o toggles every 4 cycles: 10,01,10,...
